// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: default 640x480@60 timing constants,
// helpers that derive totals and counter widths from them, and the
// per-pixel sync/blank flag bundle used by the sync generator.
package vga_timing_pkg;

    // Default 640x480@60 timing, 100 MHz system clock divided to 25 MHz.
    localparam int unsigned DEF_SCREEN_WIDTH = 10;
    localparam int unsigned DEF_CLK_DIV      = 4;

    localparam int unsigned DEF_H_DISPLAY    = 640;
    localparam int unsigned DEF_H_FRONT      = 16;
    localparam int unsigned DEF_H_SYNC       = 96;
    localparam int unsigned DEF_H_BACK       = 48;

    localparam int unsigned DEF_V_DISPLAY    = 480;
    localparam int unsigned DEF_V_FRONT      = 10;
    localparam int unsigned DEF_V_SYNC       = 2;
    localparam int unsigned DEF_V_BACK       = 33;

    // Sync and blanking flags decoded for one pixel position.
    typedef struct packed {
        logic hsync;     // active low
        logic vsync;     // active low
        logic video_on;  // inside the visible area
    } sync_flags_t;

    // Total length of a line or frame (H_TOTAL / V_TOTAL).
    function automatic int unsigned line_total(
        input int unsigned display,
        input int unsigned front,
        input int unsigned sync,
        input int unsigned back
    );
        return display + front + sync + back;
    endfunction

    // Bits needed to hold 0..total-1; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

    // True when val lies in [lo, lo+len-1].
    function automatic logic in_window(
        input int unsigned val,
        input int unsigned lo,
        input int unsigned len
    );
        return (val >= lo) && (val < lo + len);
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel clock-enable generator.
// Ports:
//   sys_clk - system clock
//   sys_rst - synchronous active-high reset
//   p_tick  - one-sys_clk strobe every CLK_DIV cycles
// div_cnt runs 0..CLK_DIV-1; p_tick is registered from the next count so it
// is high exactly in the cycle where div_cnt == CLK_DIV-1.
module pixel_tick_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic sys_clk,
    input  logic sys_rst,
    output logic p_tick
);

    localparam int unsigned DIV_W = cnt_width(CLK_DIV);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;

    // Wrapping divider count.
    always_comb begin
        div_next = div_cnt + DIV_W'(1);
        if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
            div_next = '0;
        end
    end

    // Counter and strobe registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            div_cnt <= '0;
            p_tick  <= 1'b0;
        end else begin
            div_cnt <= div_next;
            p_tick  <= (div_next == DIV_W'(CLK_DIV - 1));
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: pixel/line counters with registered sync, blanking
// and coordinate outputs.
// Ports:
//   sys_clk     - system clock
//   sys_rst     - synchronous active-high reset
//   hsync       - horizontal sync, active low
//   vsync       - vertical sync, active low
//   video_on    - current pixel is in the active area
//   p_tick      - one-sys_clk pixel-enable strobe
//   x, y        - current pixel column / line
//   frame_start - one-cycle pulse with the first x=0,y=0 of a frame
// All registered outputs change only on the edge that closes a p_tick cycle,
// so they stay mutually aligned and hold between pixel strobes.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH = DEF_SCREEN_WIDTH,
    parameter int unsigned CLK_DIV      = DEF_CLK_DIV,
    parameter int unsigned H_DISPLAY    = DEF_H_DISPLAY,
    parameter int unsigned H_FRONT      = DEF_H_FRONT,
    parameter int unsigned H_SYNC       = DEF_H_SYNC,
    parameter int unsigned H_BACK       = DEF_H_BACK,
    parameter int unsigned V_DISPLAY    = DEF_V_DISPLAY,
    parameter int unsigned V_FRONT      = DEF_V_FRONT,
    parameter int unsigned V_SYNC       = DEF_V_SYNC,
    parameter int unsigned V_BACK       = DEF_V_BACK
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    video_on,
    output logic                    p_tick,
    output logic [SCREEN_WIDTH-1:0] x,
    output logic [SCREEN_WIDTH-1:0] y,
    output logic                    frame_start
);

    localparam int unsigned H_TOTAL  = line_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL  = line_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
    localparam int unsigned H_CNT_W  = cnt_width(H_TOTAL);
    localparam int unsigned V_CNT_W  = cnt_width(V_TOTAL);
    localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
    localparam int unsigned VS_START = V_DISPLAY + V_FRONT;

    logic [H_CNT_W-1:0] h_cnt;
    logic [H_CNT_W-1:0] h_next;
    logic [V_CNT_W-1:0] v_cnt;
    logic [V_CNT_W-1:0] v_next;
    logic               h_wrap;
    logic               v_wrap;
    sync_flags_t        flags_next;

    // Pixel-rate strobe.
    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_gen (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .p_tick  (p_tick)
    );

    // Next counter position and the flags that belong to it; decoding the
    // next position lets the flags register on the same edge as the counters.
    always_comb begin
        h_wrap     = (h_cnt == H_CNT_W'(H_TOTAL - 1));
        v_wrap     = (v_cnt == V_CNT_W'(V_TOTAL - 1));
        h_next     = h_cnt + H_CNT_W'(1);
        v_next     = v_cnt;
        flags_next = '0;

        if (h_wrap) begin
            h_next = '0;
            v_next = v_wrap ? '0 : (v_cnt + V_CNT_W'(1));
        end

        flags_next.hsync    = ~in_window(32'(h_next), HS_START, H_SYNC);
        flags_next.vsync    = ~in_window(32'(v_next), VS_START, V_SYNC);
        flags_next.video_on = (32'(h_next) < H_DISPLAY) && (32'(v_next) < V_DISPLAY);
    end

    // Counters and registered outputs; both counters wrap on the same edge
    // at the end of a frame.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (p_tick) begin
                h_cnt       <= h_next;
                v_cnt       <= v_next;
                hsync       <= flags_next.hsync;
                vsync       <= flags_next.vsync;
                video_on    <= flags_next.video_on;
                frame_start <= h_wrap && v_wrap;
            end
        end
    end

    // Coordinates are the counter flops themselves.
    assign x = SCREEN_WIDTH'(h_cnt);
    assign y = SCREEN_WIDTH'(v_cnt);

endmodule
